// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard types: prefix byte values, frame length and the event record.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // bits[0]=start, bits[8:1]=data, bits[9]=odd parity; stop is the bit arriving last
   function automatic logic ps2_frame_ok(input logic [9:0] bits, input logic stop);
      return !bits[0] && stop && (^bits[9:1]);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO, registered (no fall-through): a pushed entry is visible the next cycle.
module ps2_evt_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  ps2_evt_t               din,
   input  logic                   pop,
   output ps2_evt_t               dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   ps2_evt_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; dout is masked while empty so stale data never leaks.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_kbd_evt_rx.sv
// PS/2 keyboard receiver: synchronisers, 11-bit deframer, E0/F0 prefix folding, event FIFO.
// Optional partial-frame abort is enabled by defining PS2_FRAME_TIMEOUT_EN.
module ps2_kbd_evt_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [7:0]                    evt_code,
   output logic                          evt_ext,
   output logic                          evt_brk,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_frame,
   output logic                          err_ovf
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   strobe;
   logic                   data_bit;
   logic [3:0]             bit_cnt;
   logic [9:0]             shift;
   logic                   frame_end;
   logic                   frame_good;
   logic                   byte_vld;
   logic [7:0]             byte_q;
   logic                   ext_q;
   logic                   brk_q;
   logic                   timeout;
   logic                   push;
   logic                   full;
   logic                   empty;
   ps2_evt_t               head;

   // bit 0 is the newest sample; reset to all-1 so an idle bus never fakes a falling edge
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign strobe     = clk_sync[SYNC_STAGES-1] && !clk_sync[SYNC_STAGES-2];
   assign data_bit   = data_sync[SYNC_STAGES-1];
   assign frame_end  = strobe && (bit_cnt == 4'(PS2_FRAME_BITS - 1));
   assign frame_good = ps2_frame_ok(shift, data_bit);

`ifdef PS2_FRAME_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   logic [IW-1:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (!resetn || strobe || bit_cnt == '0) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;
   end

   assign timeout = !strobe && (bit_cnt != '0) && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bit_cnt   <= '0;
         shift     <= '0;
         byte_vld  <= 1'b0;
         byte_q    <= '0;
         err_frame <= 1'b0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         byte_vld  <= 1'b0;
         err_frame <= 1'b0;
         if (frame_end) begin
            bit_cnt <= '0;
            if (frame_good) begin
               byte_vld <= 1'b1;
               byte_q   <= shift[8:1];
            end else begin
               err_frame <= 1'b1;
            end
         end else if (strobe) begin
            bit_cnt <= bit_cnt + 4'd1;
            shift   <= {data_bit, shift[9:1]};
         end else if (timeout) begin
            bit_cnt   <= '0;
            err_frame <= 1'b1;
         end

         // a corrupted or aborted frame also forgets any pending prefix
         if ((frame_end && !frame_good) || timeout) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_vld) begin
            case (byte_q)
               PS2_PFX_EXT: ext_q <= 1'b1;
               PS2_PFX_BRK: brk_q <= 1'b1;
               default: begin
                  ext_q <= 1'b0;
                  brk_q <= 1'b0;
               end
            endcase
         end

         err_ovf <= push && full && !(evt_ready && !empty);
      end
   end

   assign push = byte_vld && (byte_q != PS2_PFX_EXT) && (byte_q != PS2_PFX_BRK);

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .din    ('{ext: ext_q, brk: brk_q, code: byte_q}),
      .pop    (evt_ready),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .count  (fifo_count)
   );

   assign evt_valid = !empty;
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_brk   = head.brk;

endmodule

// File: tb/tb_ps2_kbd_evt_rx.sv
// Directed bench for ps2_kbd_evt_rx: bit-banged PS/2 frames, prefix model and event scoreboard.
module tb_ps2_kbd_evt_rx;
   import ps2_pkg::*;

   localparam int DEPTH = 8;
   localparam int HALF  = 20;
   localparam int TO    = 200;

   logic                     clk;
   logic                     resetn;
   logic                     ps2_clk;
   logic                     ps2_data;
   logic                     evt_valid;
   logic                     evt_ready;
   logic [7:0]               evt_code;
   logic                     evt_ext;
   logic                     evt_brk;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     err_frame;
   logic                     err_ovf;

   int       total = 0;
   int       bad   = 0;
   int       n_ferr = 0;
   int       n_ovf  = 0;
   int       lat_valid;
   int       lat_err;
   int       snap;
   logic     m_ext = 1'b0;
   logic     m_brk = 1'b0;
   ps2_evt_t exp_q [$];

   ps2_kbd_evt_rx #(
      .FIFO_DEPTH     (DEPTH),
      .SYNC_STAGES    (3),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_brk    (evt_brk),
      .fifo_count (fifo_count),
      .err_frame  (err_frame),
      .err_ovf    (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_frame) n_ferr++;
      if (err_ovf)   n_ovf++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // nbits < 11 leaves a partial frame; pop_at_push raises evt_ready for exactly the push cycle
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit pop_at_push);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      lat_valid = 0;
      lat_err   = 0;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (i == 10) begin
               if (lat_valid == 0 && evt_valid) lat_valid = k;
               if (lat_err == 0 && err_frame)   lat_err   = k;
               if (pop_at_push && k == 3) evt_ready = 1'b1;
               if (pop_at_push && k == 4) evt_ready = 1'b0;
            end
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_key(input logic [7:0] b, input bit pop_at_push = 1'b0);
      send_frame(b, 1'b0, 11, pop_at_push);
      if (b == PS2_PFX_EXT) m_ext = 1'b1;
      else if (b == PS2_PFX_BRK) m_brk = 1'b1;
      else begin
         if (exp_q.size() < DEPTH) exp_q.push_back('{ext: m_ext, brk: m_brk, code: b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_bad(input logic [7:0] b);
      send_frame(b, 1'b1, 11, 1'b0);
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic drain();
      ps2_evt_t exp;
      int       budget;
      budget = 400;
      while (exp_q.size() > 0 && budget > 0) begin
         budget--;
         if (evt_valid) begin
            exp = exp_q.pop_front();
            check("evt", {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, exp});
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      if (exp_q.size() > 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      check("drain_valid", evt_valid, 0);
      check("drain_count", fifo_count, 0);
   endtask

   initial begin
      resetn    = 1'b0;
      ps2_clk   = 1'b1;
      ps2_data  = 1'b1;
      evt_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", evt_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_err_frame", err_frame, 0);
      check("rst_err_ovf", err_ovf, 0);
      check("rst_code", evt_code, 0);
      check("rst_ext", evt_ext, 0);
      check("rst_brk", evt_brk, 0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // single make code and its latency from the stop-bit fall
      send_key(8'h1C);
      check("lat_valid", lat_valid, 4);
      check("count_1c", fifo_count, 1);
      drain();

      // F0 produces no event on its own
      send_key(PS2_PFX_BRK);
      check("count_f0", fifo_count, 0);
      send_key(8'h1C);
      check("count_f0_1c", fifo_count, 1);
      drain();

      // E0 F0 75 release followed by a plain 75 make
      send_key(PS2_PFX_EXT);
      send_key(PS2_PFX_BRK);
      send_key(8'h75);
      send_key(8'h75);
      check("count_e0f0", fifo_count, 2);
      drain();

      // parity error, then a prefix that a bad frame must cancel
      snap = n_ferr;
      send_bad(8'h1C);
      check("lat_err", lat_err, 3);
      check("perr_pulses", n_ferr - snap, 1);
      check("perr_count", fifo_count, 0);
      send_key(PS2_PFX_EXT);
      send_bad(8'h11);
      send_key(8'h74);
      check("perr2_pulses", n_ferr - snap, 2);
      drain();

      // overflow with the consumer stalled, then push and pop together while full
      snap = n_ovf;
      for (int i = 0; i < DEPTH + 1; i++) send_key(8'h15 + 8'(i));
      check("ovf_count", fifo_count, DEPTH);
      check("ovf_pulses", n_ovf - snap, 1);
      void'(exp_q.pop_front());
      send_key(8'h2A, 1'b1);
      check("full_pp_count", fifo_count, DEPTH);
      check("full_pp_ovf", n_ovf - snap, 1);
      drain();

      // partial frame after a prefix, left idle
      snap = n_ferr;
      send_key(PS2_PFX_EXT);
      send_frame(8'h33, 1'b0, 4, 1'b0);
      repeat (TO + 50) @(negedge clk);
`ifdef PS2_FRAME_TIMEOUT_EN
      check("timeout_pulse", n_ferr - snap, 1);
      m_ext = 1'b0;
      m_brk = 1'b0;
`else
      check("no_timeout", n_ferr - snap, 0);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
      check("midreset_count", fifo_count, 0);
      check("midreset_valid", evt_valid, 0);
`endif
      send_key(8'h29);
      check("recover_count", fifo_count, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
